// File: rtl/dsp38_seq_pkg.sv
// Shared widths, feedback codes, FSM states and frame-config bundle for the DSP38 MAC sequencer.
package dsp38_seq_pkg;

  localparam int A_W     = 20;
  localparam int B_W     = 18;
  localparam int Z_W     = 38;
  localparam int SHIFT_W = 6;

  localparam logic [2:0] FB_ACCUM = 3'd0;
  localparam logic [2:0] FB_LOAD  = 3'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  typedef struct packed {
    logic               unsigned_a;
    logic               unsigned_b;
    logic               saturate;
    logic               round;
    logic [SHIFT_W-1:0] shift_right;
  } cfg_t;

endpackage

// File: rtl/dsp38_seq_issue.sv
// Registered DSP38 drive stage: puts accepted operand pairs on the DSP inputs one edge later,
// zeroes them on bubbles, and holds the frame config between frame starts.
module dsp38_seq_issue
  import dsp38_seq_pkg::*;
(
  input  logic           CLK,
  input  logic           RESET,
  input  logic           cfg_load,
  input  cfg_t           cfg,
  input  logic           accept,
  input  logic           first_term,
  input  logic [A_W-1:0] op_a,
  input  logic [B_W-1:0] op_b,
  output logic [A_W-1:0] dsp_a,
  output logic [B_W-1:0] dsp_b,
  output logic           dsp_load_acc,
  output logic [2:0]     dsp_feedback,
  output cfg_t           dsp_cfg
);

  cfg_t cfg_q;

  // Zero operands with LOAD_ACC low keep the accumulator frozen on non-accepting cycles.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      dsp_a        <= '0;
      dsp_b        <= '0;
      dsp_load_acc <= 1'b0;
      dsp_feedback <= FB_ACCUM;
      cfg_q        <= '0;
    end else begin
      dsp_load_acc <= accept;
      dsp_a        <= accept ? op_a : '0;
      dsp_b        <= accept ? op_b : '0;
      dsp_feedback <= (accept && first_term) ? FB_LOAD : FB_ACCUM;
      if (cfg_load) begin
        cfg_q <= cfg;
      end
    end
  end

  assign dsp_cfg = cfg_q;

endmodule

// File: rtl/dsp38_mac_sequencer.sv
// Frame controller for a DSP38 in multiply-accumulate mode: streams operand pairs into the DSP,
// waits out the DSP pipeline, then captures Z and holds it on a valid/ready result port.
module dsp38_mac_sequencer
  import dsp38_seq_pkg::*;
#(
  parameter  int MAX_TERMS   = 64,
  parameter  int DSP_LATENCY = 1,
  localparam int NT_W        = $clog2(MAX_TERMS + 1)
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               START,
  input  logic [NT_W-1:0]    NUM_TERMS,
  input  logic               CFG_UNSIGNED_A,
  input  logic               CFG_UNSIGNED_B,
  input  logic               CFG_SATURATE,
  input  logic               CFG_ROUND,
  input  logic [SHIFT_W-1:0] CFG_SHIFT_RIGHT,
  output logic               BUSY,
  input  logic               OP_VALID,
  output logic               OP_READY,
  input  logic [A_W-1:0]     OP_A,
  input  logic [B_W-1:0]     OP_B,
  output logic [A_W-1:0]     DSP_A,
  output logic [B_W-1:0]     DSP_B,
  output logic               DSP_LOAD_ACC,
  output logic [2:0]         DSP_FEEDBACK,
  output logic               DSP_SUBTRACT,
  output logic               DSP_UNSIGNED_A,
  output logic               DSP_UNSIGNED_B,
  output logic               DSP_SATURATE,
  output logic               DSP_ROUND,
  output logic [SHIFT_W-1:0] DSP_SHIFT_RIGHT,
  input  logic [Z_W-1:0]     DSP_Z,
  output logic               RES_VALID,
  input  logic               RES_READY,
  output logic [Z_W-1:0]     RES_DATA
);

  state_t          state;
  logic [NT_W-1:0] terms_left;
  logic [1:0]      drain_cnt;
  logic            first_term;
  logic [Z_W-1:0]  res_q;
  logic            accept;
  logic            frame_start;
  logic [NT_W-1:0] num_clamped;
  cfg_t            cfg_in;
  cfg_t            cfg_q;

  assign OP_READY    = (state == ISSUE);
  assign accept      = OP_READY & OP_VALID;
  assign frame_start = (state == IDLE) & START;
  assign num_clamped = (NUM_TERMS > NT_W'(MAX_TERMS)) ? NT_W'(MAX_TERMS) : NUM_TERMS;

  assign cfg_in = '{unsigned_a:  CFG_UNSIGNED_A,
                    unsigned_b:  CFG_UNSIGNED_B,
                    saturate:    CFG_SATURATE,
                    round:       CFG_ROUND,
                    shift_right: CFG_SHIFT_RIGHT};

  // Drain spans DSP_LATENCY+1 edges after the last accept so Z is sampled once it includes that term.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      terms_left <= '0;
      drain_cnt  <= '0;
      first_term <= 1'b0;
      res_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            if (NUM_TERMS == '0) begin
              res_q <= '0;
              state <= HOLD;
            end else begin
              terms_left <= num_clamped;
              first_term <= 1'b1;
              state      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (OP_VALID) begin
            first_term <= 1'b0;
            terms_left <= terms_left - NT_W'(1);
            if (terms_left == NT_W'(1)) begin
              drain_cnt <= 2'(DSP_LATENCY);
              state     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == 2'd0) begin
            res_q <= DSP_Z;
            state <= HOLD;
          end else begin
            drain_cnt <= drain_cnt - 2'd1;
          end
        end
        HOLD: begin
          if (RES_READY) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  dsp38_seq_issue u_issue (
    .CLK          (CLK),
    .RESET        (RESET),
    .cfg_load     (frame_start),
    .cfg          (cfg_in),
    .accept       (accept),
    .first_term   (first_term),
    .op_a         (OP_A),
    .op_b         (OP_B),
    .dsp_a        (DSP_A),
    .dsp_b        (DSP_B),
    .dsp_load_acc (DSP_LOAD_ACC),
    .dsp_feedback (DSP_FEEDBACK),
    .dsp_cfg      (cfg_q)
  );

  assign DSP_SUBTRACT    = 1'b0;
  assign DSP_UNSIGNED_A  = cfg_q.unsigned_a;
  assign DSP_UNSIGNED_B  = cfg_q.unsigned_b;
  assign DSP_SATURATE    = cfg_q.saturate;
  assign DSP_ROUND       = cfg_q.round;
  assign DSP_SHIFT_RIGHT = cfg_q.shift_right;

  assign BUSY      = (state != IDLE);
  assign RES_VALID = (state == HOLD);
  assign RES_DATA  = res_q;

endmodule

// File: tb/tb_dsp38_mac_sequencer.sv
// Bench for dsp38_mac_sequencer: two instances (DSP latency 1 and 3) share one stimulus stream,
// each with an accumulator model of the DSP38 and a frame-level reference model.
module tb_dsp38_mac_sequencer;

  typedef struct packed {
    logic        busy;
    logic        op_ready;
    logic        res_valid;
    logic [37:0] res_data;
    logic        load;
    logic [19:0] a;
    logic [17:0] b;
    logic [2:0]  fb;
    logic        sub;
    logic        ua;
    logic        ub;
    logic        sat;
    logic        rnd;
    logic [5:0]  shift;
  } obs_t;

  typedef struct packed {
    logic        cap;
    int          frame;
    logic [37:0] res;
    int          dly;
    int          loads;
  } pin_t;

  typedef struct packed {
    logic        load;
    logic [2:0]  fb;
    logic        ua;
    logic        ub;
    logic [19:0] a;
    logic [17:0] b;
  } drv_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [6:0]  num;
  logic        cua, cub, csat, crnd;
  logic [5:0]  cshift;
  logic        op_valid;
  logic [19:0] op_a;
  logic [17:0] op_b;
  logic        res_ready;

  int n_checks = 0;
  int n_fail   = 0;

  // Hand-computed per-frame expectations for the directed frames 0..7 (frame 6 is cut by reset).
  logic [37:0] exp_res   [8] = '{38'd9, 38'd22, 38'd3, 38'd0, 38'd25, 38'd42, 38'd0, 38'd2};
  int          exp_loads [8] = '{3, 2, 2, 0, 1, 1, 0, 2};
  int          exp_dly1  [8] = '{5, 6, 4, 0, 3, 3, 0, 4};
  int          exp_dly3  [8] = '{7, 8, 6, 0, 5, 5, 0, 6};

  initial forever #5 clk = ~clk;

  function automatic logic [37:0] prod38(input logic [19:0] a, input logic [17:0] b,
                                         input logic ua, input logic ub);
    longint av, bv;
    av = longint'(a);
    bv = longint'(b);
    if (!ua && a[19]) av = av - 64'sd1048576;
    if (!ub && b[17]) bv = bv - 64'sd262144;
    return 38'(av * bv);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 1 : 3;
    localparam int PI  = (LAT > 1) ? LAT - 2 : 0;

    logic        w_busy, w_rdy, w_rv, w_load, w_sub, w_ua, w_ub, w_sat, w_rnd;
    logic [37:0] w_res;
    logic [19:0] w_a;
    logic [17:0] w_b;
    logic [2:0]  w_fb;
    logic [5:0]  w_sh;
    logic [37:0] acc;
    obs_t        act;
    obs_t        ex;
    pin_t        pin;
    drv_t        cur, src;
    drv_t        pipe [2];

    dsp38_mac_sequencer #(.MAX_TERMS(64), .DSP_LATENCY(LAT)) u_dut (
      .CLK(clk), .RESET(rst), .START(start), .NUM_TERMS(num),
      .CFG_UNSIGNED_A(cua), .CFG_UNSIGNED_B(cub), .CFG_SATURATE(csat), .CFG_ROUND(crnd),
      .CFG_SHIFT_RIGHT(cshift), .BUSY(w_busy), .OP_VALID(op_valid), .OP_READY(w_rdy),
      .OP_A(op_a), .OP_B(op_b), .DSP_A(w_a), .DSP_B(w_b), .DSP_LOAD_ACC(w_load),
      .DSP_FEEDBACK(w_fb), .DSP_SUBTRACT(w_sub), .DSP_UNSIGNED_A(w_ua), .DSP_UNSIGNED_B(w_ub),
      .DSP_SATURATE(w_sat), .DSP_ROUND(w_rnd), .DSP_SHIFT_RIGHT(w_sh), .DSP_Z(acc),
      .RES_VALID(w_rv), .RES_READY(res_ready), .RES_DATA(w_res)
    );

    always_comb begin
      act = '{busy: w_busy, op_ready: w_rdy, res_valid: w_rv, res_data: w_res, load: w_load,
              a: w_a, b: w_b, fb: w_fb, sub: w_sub, ua: w_ua, ub: w_ub, sat: w_sat,
              rnd: w_rnd, shift: w_sh};
    end

    // DSP38 accumulator with LAT-1 input-side register stages; rounding/saturation not modelled.
    assign cur = '{load: w_load, fb: w_fb, ua: w_ua, ub: w_ub, a: w_a, b: w_b};
    assign src = (LAT == 1) ? cur : pipe[PI];

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        acc     <= '0;
        pipe[0] <= '0;
        pipe[1] <= '0;
      end else begin
        pipe[0] <= cur;
        pipe[1] <= pipe[0];
        if (src.load)
          acc <= ((src.fb == 3'd1) ? 38'd0 : acc) + prod38(src.a, src.b, src.ua, src.ub);
      end
    end

    // Frame-level reference: terms outstanding, edges until the result lands, result pending.
    int          m_left, m_wait, m_edges, m_start, m_loads, m_cur;
    int          m_frames = 0;
    bit          m_busy, m_hold, m_first;
    logic [37:0] m_sum;

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        m_left = 0; m_wait = 0; m_busy = 0; m_hold = 0; m_first = 0; m_sum = '0;
        ex = '0; pin = '0;
      end else begin
        m_edges++;
        pin.cap = 1'b0;
        ex.load = 1'b0; ex.a = '0; ex.b = '0; ex.fb = 3'd0;
        if (m_hold) begin
          if (res_ready) begin m_hold = 0; m_busy = 0; end
        end else if (m_wait > 0) begin
          m_wait--;
          if (m_wait == 0) begin
            m_hold = 1;
            ex.res_data = m_sum;
            pin = '{1'b1, m_cur, m_sum, m_edges - m_start, m_loads};
          end
        end else if (m_left > 0) begin
          if (op_valid) begin
            ex.load = 1'b1; ex.a = op_a; ex.b = op_b; ex.fb = m_first ? 3'd1 : 3'd0;
            m_sum = (m_first ? 38'd0 : m_sum) + prod38(op_a, op_b, ex.ua, ex.ub);
            m_first = 0; m_left--; m_loads++;
            if (m_left == 0) m_wait = LAT + 1;
          end
        end else if (!m_busy && start) begin
          m_busy = 1; m_cur = m_frames; m_frames++; m_start = m_edges; m_loads = 0;
          ex.ua = cua; ex.ub = cub; ex.sat = csat; ex.rnd = crnd; ex.shift = cshift;
          if (num == 7'd0) begin
            m_hold = 1;
            ex.res_data = '0;
            pin = '{1'b1, m_cur, 38'd0, 0, 0};
          end else begin
            m_left  = (num > 7'd64) ? 64 : int'(num);
            m_first = 1;
          end
        end
        ex.busy      = m_busy;
        ex.op_ready  = m_busy && (m_left > 0);
        ex.res_valid = m_hold;
      end
    end
  end

  task automatic cmp(input string nm, input int lat, input logic [63:0] a, input logic [63:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s (latency %0d) at %0t: actual=%0h required=%0h", nm, lat, $time, a, e);
    end
  endtask

  task automatic check_inst(input int lat, input obs_t a, input obs_t e, input pin_t p);
    cmp("BUSY", lat, 64'(a.busy), 64'(e.busy));
    cmp("OP_READY", lat, 64'(a.op_ready), 64'(e.op_ready));
    cmp("RES_VALID", lat, 64'(a.res_valid), 64'(e.res_valid));
    cmp("RES_DATA", lat, 64'(a.res_data), 64'(e.res_data));
    cmp("DSP_LOAD_ACC", lat, 64'(a.load), 64'(e.load));
    cmp("DSP_A", lat, 64'(a.a), 64'(e.a));
    cmp("DSP_B", lat, 64'(a.b), 64'(e.b));
    cmp("DSP_FEEDBACK", lat, 64'(a.fb), 64'(e.fb));
    cmp("DSP_SUBTRACT", lat, 64'(a.sub), 64'(e.sub));
    cmp("DSP_CFG", lat, 64'({a.ua, a.ub, a.sat, a.rnd, a.shift}),
        64'({e.ua, e.ub, e.sat, e.rnd, e.shift}));
    if (p.cap && p.frame < 8) begin
      cmp("frame_result", lat, 64'(p.res), 64'(exp_res[p.frame]));
      cmp("frame_loads", lat, 64'(p.loads), 64'(exp_loads[p.frame]));
      cmp("frame_latency", lat, 64'(p.dly),
          64'((lat == 1) ? exp_dly1[p.frame] : exp_dly3[p.frame]));
    end
  endtask

  always @(negedge clk) begin
    check_inst(1, g_inst[0].act, g_inst[0].ex, g_inst[0].pin);
    check_inst(3, g_inst[1].act, g_inst[1].ex, g_inst[1].pin);
  end

  task automatic idle(input int k);
    op_valid = 1'b0;
    repeat (k) @(negedge clk);
  endtask

  task automatic start_frame(input logic [6:0] n, input logic ua, input logic ub);
    start = 1'b1; num = n; cua = ua; cub = ub;
    csat = 1'($urandom); crnd = 1'($urandom); cshift = 6'($urandom);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push(input logic [19:0] a, input logic [17:0] b);
    op_valid = 1'b1; op_a = a; op_b = b;
    @(negedge clk);
    op_valid = 1'b0; op_a = 20'($urandom); op_b = 18'($urandom);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num = '0; cua = 0; cub = 0; csat = 0; crnd = 0; cshift = '0;
    op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b1;
    idle(3); rst = 1'b0; idle(2);

    start_frame(7'd3, 1, 1); push(20'd3, 18'd1); push(20'd3, 18'd1); push(20'd3, 18'd1); idle(8);
    start_frame(7'd2, 1, 1); push(20'd2, 18'd5); idle(2); push(20'd4, 18'd3); idle(8);
    start_frame(7'd2, 0, 0); push(20'hFFFFD, 18'd2); push(20'hFFFFD, 18'h3FFFD); idle(8);
    start_frame(7'd0, 1, 1); idle(4);

    res_ready = 1'b0;
    start_frame(7'd1, 1, 1); push(20'd5, 18'd5); idle(6);
    start_frame(7'd2, 0, 0); idle(3);
    res_ready = 1'b1; idle(3);
    start_frame(7'd1, 1, 1); push(20'd7, 18'd6); idle(8);

    start_frame(7'd4, 1, 1); push(20'd1, 18'd2); push(20'd3, 18'd4);
    @(posedge clk); #2 rst = 1'b1;
    idle(2); rst = 1'b0; idle(2);
    start_frame(7'd2, 1, 1); push(20'd1, 18'd1); push(20'd1, 18'd1); idle(8);

    for (int f = 0; f < 40; f++) begin
      int n;
      n = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
      start_frame(7'(n), 1'($urandom), 1'($urandom));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        start = ($urandom_range(0, 5) == 0);
        num = 7'($urandom); cua = 1'($urandom); cub = 1'($urandom); cshift = 6'($urandom);
        push(20'($urandom), 18'($urandom));
        start = 1'b0;
      end
      op_valid = 1'b1; op_a = 20'($urandom); op_b = 18'($urandom);
      repeat (2) @(negedge clk);
      res_ready = 1'($urandom);
      idle(6);
      res_ready = 1'b1;
      idle(2);
    end

    start_frame(7'd70, 1, 0);
    for (int i = 0; i < 66; i++) push(20'($urandom), 18'($urandom));
    idle(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dsp38_mac_sequencer.md
# dsp38_mac_sequencer

Frame-level controller that drives one DSP38 in MULTIPLY_ACCUMULATE mode to compute dot products of variable length. It accepts operand pairs over a valid/ready stream and issues them to the DSP with the correct accumulator-load and feedback controls. After the DSP pipeline drains, it captures Z and presents the result over a second valid/ready stream. It sits between a requester (FIR or matrix engine) and the DSP38 primitive; the DSP38's RESET is tied to this block's RESET.

## Interface
- MAX_TERMS, 64: maximum terms per frame; NUM_TERMS above this is clamped.
- DSP_LATENCY, 1: CLK edges from DSP inputs being driven until Z includes that term. Legal range 1..3: 1 = no DSP registers, 2 = INPUT or OUTPUT reg, 3 = both.
- CLK  in  1  sole clock.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  one-cycle frame request; sampled only in IDLE.
- NUM_TERMS  in  $clog2(MAX_TERMS+1)  terms in frame, sampled with START.
- CFG_UNSIGNED_A, CFG_UNSIGNED_B, CFG_SATURATE, CFG_ROUND  in  1 each  frame config, sampled with START.
- CFG_SHIFT_RIGHT  in  6  frame config, sampled with START.
- BUSY  out  1  high whenever state is not IDLE.
- OP_VALID / OP_READY  in / out  1  operand handshake.
- OP_A  in  20  operand A.
- OP_B  in  18  operand B.
- DSP_A, DSP_B  out  20, 18  registered operand drive to the DSP38.
- DSP_LOAD_ACC  out  1  registered accumulator-load drive.
- DSP_FEEDBACK  out  3  registered feedback drive.
- DSP_SUBTRACT, DSP_UNSIGNED_A, DSP_UNSIGNED_B, DSP_SATURATE, DSP_ROUND  out  1 each  registered DSP controls.
- DSP_SHIFT_RIGHT  out  6  registered DSP control.
- DSP_Z  in  38  accumulator output from the DSP38.
- RES_VALID / RES_READY  out / in  1  result handshake.
- RES_DATA  out  38  captured result.

## Operation
- States:
  - IDLE → ISSUE on START with NUM_TERMS ≠ 0.
  - IDLE → HOLD on START with NUM_TERMS = 0: RES_DATA = 0 and the DSP is never touched.
  - ISSUE → DRAIN when the last term is accepted.
  - DRAIN → HOLD after the drain count.
  - HOLD → IDLE on RES_VALID & RES_READY.
- OP_READY = (state == ISSUE), combinational from state only.
- Term counter loads min(NUM_TERMS, MAX_TERMS) and decrements on each handshake.
- Each accepted pair is registered onto DSP_A/DSP_B with DSP_LOAD_ACC = 1 on the next edge.
  - First term of a frame: DSP_FEEDBACK = 3'd1, which loads the fresh product and discards the old accumulator.
  - Later terms: DSP_FEEDBACK = 3'd0 (accumulate).
- Bubble cycles (ISSUE without a handshake), DRAIN and HOLD: DSP_LOAD_ACC = 0, DSP_A = DSP_B = 0, so the accumulator holds.
- DSP_SUBTRACT is always 0. Other DSP controls hold the frame config from START until the next START.
- Config and NUM_TERMS are ignored outside IDLE. START while busy is dropped, not queued.
- RES_DATA is a register written once per frame, on the DRAIN→HOLD edge, from DSP_Z. It holds until the next capture.

## Timing
- Reset values:
  - State IDLE.
  - BUSY, OP_READY, RES_VALID = 0.
  - RES_DATA = 0.
  - All DSP_* outputs = 0.
- Reset is asynchronous: outputs reach reset values without waiting for CLK.
- Last operand handshake at edge t: DSP inputs are valid in cycle t+1, and DSP_Z is final after edge t+DSP_LATENCY.
- The DRAIN counter runs DSP_LATENCY cycles. RES_DATA is captured and RES_VALID rises at edge t+DSP_LATENCY+1.
- Minimum frame (N terms, no stalls): START edge s; handshakes at s+1..s+N; RES_VALID at s+N+DSP_LATENCY+1.
- RES_VALID and RES_DATA stay stable until accepted. The return to IDLE happens on the accepting edge.
- START may be asserted in the cycle after that accept.
- RESET mid-frame abandons the frame. The DSP is reset by the same RESET, so no stale accumulator survives.

## Structure
- Package dsp38_seq_pkg holds:
  - state enum {IDLE, ISSUE, DRAIN, HOLD};
  - widths A_W=20, B_W=18, Z_W=38, SHIFT_W=6;
  - feedback codes FB_ACCUM=3'd0, FB_LOAD=3'd1.
- One sub-module: dsp38_seq_issue. It contains the registered DSP drive stage and its first-term/bubble muxing. The FSM, counters and result register stay in the top.

## Test plan
- Nominal, DSP_LATENCY=1, unsigned: N=3, pairs (3,1)×3 → RES_DATA=9; RES_VALID 5 edges after START; exactly 3 DSP_LOAD_ACC pulses, the first with DSP_FEEDBACK=1.
- Stalls: N=2, pairs (2,5),(4,3), OP_VALID low 2 cycles between them → RES_DATA=22; DSP_LOAD_ACC=0 during the bubbles.
- Signed with DSP_LATENCY=3: CFG_UNSIGNED_A=B=0, pairs (−3,2),(−3,−3) → RES_DATA=3 (38-bit two's complement); RES_VALID exactly 3 cycles after the last DSP drive.
- Zero-length: START with NUM_TERMS=0 → RES_VALID next edge, RES_DATA=0, no DSP_LOAD_ACC activity.
- Backpressure: RES_READY low 5 cycles with a START pulse in that window → RES_DATA stable, BUSY=1, START ignored; accept, then a fresh START with N=1, pair (7,6) → 42.
- Reset mid-frame: N=4, assert RESET after 2 handshakes → all outputs at reset values within the reset cycle; then N=2, pairs (1,1),(1,1) → RES_DATA=2.
